// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the per-core request buses and the single shared RAM port.
//   core_addr/core_data_w : packed per-core address and write data (core i at [i*W +: W])
//   core_read/write/atomic: per-core request strobes and atomic qualifier
//   core_wait             : per-core stall back to the cores
//   core_data_r           : read data broadcast to every core
//   ram_*                 : request toward the shared RAM, ram_data_r/ram_wait back
// Modports: master = arbiter view, slave = environment (cores + RAM) view.
interface mem_arbiter_if #(
  parameter int N_CORES = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32
);
  logic [N_CORES*ADDR_W-1:0] core_addr;
  logic [N_CORES*DATA_W-1:0] core_data_w;
  logic [N_CORES-1:0]        core_read;
  logic [N_CORES-1:0]        core_write;
  logic [N_CORES-1:0]        core_atomic;
  logic [N_CORES-1:0]        core_wait;
  logic [DATA_W-1:0]         core_data_r;

  logic [ADDR_W-1:0]         ram_addr;
  logic [DATA_W-1:0]         ram_data_w;
  logic [DATA_W-1:0]         ram_data_r;
  logic                      ram_read;
  logic                      ram_write;
  logic                      ram_atomic;
  logic                      ram_wait;

  modport master (
    input  core_addr, core_data_w, core_read, core_write, core_atomic,
    input  ram_data_r, ram_wait,
    output core_wait, core_data_r,
    output ram_addr, ram_data_w, ram_read, ram_write, ram_atomic
  );

  modport slave (
    output core_addr, core_data_w, core_read, core_write, core_atomic,
    output ram_data_r, ram_wait,
    input  core_wait, core_data_r,
    input  ram_addr, ram_data_w, ram_read, ram_write, ram_atomic
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Round-robin arbiter of N_CORES requesters onto one shared RAM, with an
// atomic read/write lock that expires after LOCK_TIMEOUT idle cycles.
// Ports:
//   clk          : single clock, rising edge
//   rst_n        : synchronous active-low reset (priority over en)
//   en           : global enable; low freezes all state
//   bus          : mem_arbiter_if.master, core buses and RAM port
//   lock_timeout : one-cycle pulse when a lock is forcibly released
//
// state | meaning
// IDLE  | no grant; pick next requester after g (round-robin)
// BUSY  | core g owns the RAM for one access
// LOCK  | core g holds exclusive access after an atomic read
module mem_arbiter #(
  parameter int N_CORES      = 4,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  mem_arbiter_if.master bus,
  output logic          lock_timeout
);
  localparam int G_W   = $clog2(N_CORES);
  localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, LOCK} state_t;

  state_t             state, state_nx;
  logic [G_W-1:0]     g, g_nx;          // also serves as the last-granted pointer
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [G_W-1:0]     pick;
  logic               any_req;
  logic [N_CORES-1:0] req;
  logic [N_CORES-1:0] wait_vec;
  logic               active;
  logic               g_rd, g_wr, g_at, g_req;
  logic               done;
  logic               cnt_last;

  logic [ADDR_W-1:0]  addr_arr [N_CORES];
  logic [DATA_W-1:0]  data_arr [N_CORES];

  for (genvar i = 0; i < N_CORES; i++) begin : g_unpack
    assign addr_arr[i] = bus.core_addr[i*ADDR_W +: ADDR_W];
    assign data_arr[i] = bus.core_data_w[i*DATA_W +: DATA_W];
  end

  assign req    = bus.core_read | bus.core_write;
  // Outputs behave as IDLE while reset is held, whatever the register holds.
  assign active = rst_n && (state != IDLE);

  assign g_rd  = bus.core_read[g];
  assign g_wr  = bus.core_write[g];
  assign g_at  = bus.core_atomic[g];
  assign g_req = g_rd | g_wr;
  assign done  = active && g_req && !bus.ram_wait;

  assign cnt_last = (cnt == CNT_W'(LOCK_TIMEOUT - 1));

  assign bus.ram_addr    = addr_arr[g];
  assign bus.ram_data_w  = data_arr[g];
  assign bus.ram_read    = active & g_rd;
  assign bus.ram_write   = active & g_wr;
  assign bus.ram_atomic  = active & g_at;
  assign bus.core_data_r = bus.ram_data_r;
  assign bus.core_wait   = wait_vec;

  // Completion wins over expiry, so no pulse in a cycle that completes.
  assign lock_timeout = en && active && (state == LOCK) && !done && cnt_last;

  always_comb begin
    wait_vec = req;
    if (active) wait_vec[g] = g_req & bus.ram_wait;
  end

  // First requester strictly after g, wrapping.
  always_comb begin
    int idx;
    logic [G_W-1:0] cand;
    idx     = 0;
    cand    = '0;
    pick    = g;
    any_req = 1'b0;
    for (int k = 1; k <= N_CORES; k++) begin
      idx  = (int'(g) + k) % N_CORES;
      cand = G_W'(idx);
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
  end

  always_comb begin
    state_nx = state;
    g_nx     = g;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (any_req) begin
          g_nx     = pick;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (!g_req) begin
          state_nx = IDLE;
        end else if (done) begin
          if (g_at && g_rd && !g_wr) begin
            state_nx = LOCK;
            cnt_nx   = '0;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      LOCK: begin
        if (done) begin
          cnt_nx = '0;
          if (g_at && g_wr) state_nx = IDLE;
        end else if (cnt_last) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      g     <= G_W'(N_CORES - 1);
      cnt   <= '0;
    end else if (en) begin
      state <= state_nx;
      g     <= g_nx;
      cnt   <= cnt_nx;
    end
  end
endmodule
